nios_nios2_cpu_debug_host_scan: RTL

- Host-side initiator for the CPU debug slave's virtual-JTAG interface.
- Takes one command (IR opcode plus DR payload) and drives the full scan sequence: update-IR, capture-DR, DR_WIDTH shift cycles, update-DR.
- Returns the DR bits shifted out of the slave on tdo.
- Lets on-chip logic or a bench exercise the debug slave without a physical JTAG chain, running entirely off the system clock.

---
 rtl/nios_nios2_cpu_debug_host_scan.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nios_nios2_cpu_debug_host_scan.sv
`default_nettype none
// ============================================================================
//  Module   : nios_nios2_cpu_debug_host_scan
//  Brief    : Host-side virtual-JTAG scan initiator for the CPU debug slave.
//             Runs one command (IR + DR payload) through update-IR,
//             capture-DR, DR_WIDTH shift cycles and update-DR, returning the
//             bits shifted out of the slave on tdo.
//  Revision : 1.0 - initial release
// ============================================================================
module nios_nios2_cpu_debug_host_scan #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RSP  = 3'd5;

    // Phase counter spans one tck cycle: low half, then high half.
    localparam int                c_PH_W    = $clog2(2 * TCK_DIV) + 1;
    localparam logic [c_PH_W-1:0] c_PH_RISE = c_PH_W'(TCK_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(2 * TCK_DIV - 1);
    localparam logic [5:0]        c_BIT_LAST = 6'(DR_WIDTH - 1);

    logic [2:0]          r_state;
    logic [c_PH_W-1:0]   r_phase;
    logic [5:0]          r_bit;
    logic [DR_WIDTH-1:0] r_shift;
    logic                r_ir_loaded;
    logic [IR_WIDTH-1:0] r_ir_status;

    logic w_rise;
    logic w_wrap;

    assign cmd_ready = (r_state == S_IDLE);
    // Edge that drives tck high (tdo sampled here) and edge that ends the
    // tck cycle (state outputs change here, at the start of the low phase).
    assign w_rise    = (r_phase == c_PH_RISE);
    assign w_wrap    = (r_phase == c_PH_LAST);

    // Scan sequencer: tck generation, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_ir_loaded    <= 1'b0;
            r_ir_status    <= '0;
            rsp_valid      <= 1'b0;
            rsp_dr         <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_shift        <= cmd_dr;
                        ir_in          <= cmd_ir;
                        r_phase        <= '0;
                        r_bit          <= '0;
                        jtag_state_rti <= 1'b0;
                        // The slave already holds this instruction: skip UIR.
                        if (r_ir_loaded && (cmd_ir == ir_in)) begin
                            r_state <= S_CDR;
                            vs_cdr  <= 1'b1;
                        end else begin
                            r_state <= S_UIR;
                            vs_uir  <= 1'b1;
                        end
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_phase <= w_wrap ? '0 : r_phase + 1'b1;
                    if (w_rise) begin
                        tck <= 1'b1;
                        // Capture the pre-shift tdo bit into the MSB.
                        if (r_state == S_SDR) begin
                            r_shift <= {tdo, r_shift[DR_WIDTH-1:1]};
                        end
                    end
                    if (w_wrap) begin
                        tck <= 1'b0;
                        case (r_state)
                            S_UIR: begin
                                r_ir_loaded <= 1'b1;
                                vs_uir      <= 1'b0;
                                vs_cdr      <= 1'b1;
                                r_state     <= S_CDR;
                            end
                            S_CDR: begin
                                vs_cdr  <= 1'b0;
                                vs_sdr  <= 1'b1;
                                tdi     <= r_shift[0];
                                r_state <= S_SDR;
                            end
                            S_SDR: begin
                                if (r_bit == c_BIT_LAST) begin
                                    vs_sdr  <= 1'b0;
                                    vs_udr  <= 1'b1;
                                    tdi     <= 1'b0;
                                    r_state <= S_UDR;
                                end else begin
                                    r_bit <= r_bit + 1'b1;
                                    tdi   <= r_shift[0];
                                end
                            end
                            S_UDR: begin
                                vs_udr         <= 1'b0;
                                rsp_dr         <= r_shift;
                                rsp_valid      <= 1'b1;
                                r_ir_status    <= ir_out;
                                jtag_state_rti <= 1'b1;
                                r_state        <= S_RSP;
                            end
                            default: begin
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
